// File: rtl/rv_pkg.sv
// Shared RISC-V fetch/decode types and constants.
package rv_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned HW_W   = 16;
   localparam int unsigned QDEPTH = 4;
   localparam int unsigned CNT_W  = 3;

   typedef logic [HW_W-1:0] halfword_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   // A halfword starts a 16-bit instruction unless its two LSBs are both set.
   function automatic logic is_compressed(input halfword_t h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rvc_expand.sv
// RV32C to RV32I expander (subset); unsupported encodings flag illegal and
// return the raw halfword zero-extended.
module rvc_expand
   import rv_pkg::*;
(
   input  halfword_t         instr_i,
   output logic [XLEN-1:0]   instr_o,
   output logic              illegal_o
);

   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs1p;
   logic [11:0] imm6_sx;

   assign rd      = instr_i[11:7];
   assign rs2     = instr_i[6:2];
   assign rdp     = {2'b01, instr_i[4:2]};
   assign rs1p    = {2'b01, instr_i[9:7]};
   assign imm6_sx = {{7{instr_i[12]}}, instr_i[6:2]};

   // Decode on {funct3, quadrant}; anything not listed is reported illegal.
   always_comb begin
      instr_o   = NOP;
      illegal_o = 1'b0;
      case ({instr_i[15:13], instr_i[1:0]})
         5'b000_00: begin // c.addi4spn
            if (instr_i[12:5] == 8'h00) illegal_o = 1'b1;
            else instr_o = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6],
                            2'b00, 5'd2, 3'b000, rdp, OPC_OP_IMM};
         end
         5'b010_00: // c.lw
            instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00,
                       rs1p, 3'b010, rdp, OPC_LOAD};
         5'b110_00: // c.sw
            instr_o = {5'b0, instr_i[5], instr_i[12], rdp, rs1p, 3'b010,
                       instr_i[11:10], instr_i[6], 2'b00, OPC_STORE};
         5'b000_01: // c.addi / c.nop
            instr_o = {imm6_sx, rd, 3'b000, rd, OPC_OP_IMM};
         5'b010_01: // c.li
            instr_o = {imm6_sx, 5'd0, 3'b000, rd, OPC_OP_IMM};
         5'b011_01: begin // c.addi16sp / c.lui
            if ({instr_i[12], instr_i[6:2]} == 6'd0) illegal_o = 1'b1;
            else if (rd == 5'd2)
               instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6],
                          4'b0000, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            else
               instr_o = {{15{instr_i[12]}}, instr_i[6:2], rd, OPC_LUI};
         end
         5'b000_10: begin // c.slli
            if (instr_i[12]) illegal_o = 1'b1;
            else instr_o = {7'b0, rs2, rd, 3'b001, rd, OPC_OP_IMM};
         end
         5'b010_10: begin // c.lwsp
            if (rd == 5'd0) illegal_o = 1'b1;
            else instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00,
                            5'd2, 3'b010, rd, OPC_LOAD};
         end
         5'b110_10: // c.swsp
            instr_o = {4'b0, instr_i[8:7], instr_i[12], rs2, 5'd2, 3'b010,
                       instr_i[11:9], 2'b00, OPC_STORE};
         5'b100_10: begin // c.jr / c.mv / c.jalr / c.add
            if (rs2 == 5'd0) begin
               if (rd == 5'd0) illegal_o = 1'b1;
               else instr_o = {12'b0, rd, 3'b000, {4'b0, instr_i[12]}, OPC_JALR};
            end else if (!instr_i[12]) begin
               instr_o = {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP};
            end else begin
               instr_o = {7'b0, rs2, rd, 3'b000, rd, OPC_OP};
            end
         end
         default: illegal_o = 1'b1;
      endcase
      if (illegal_o) instr_o = {16'h0000, instr_i};
   end

endmodule

// File: rtl/instr_align.sv
// Instruction aligner: buffers fetched words as halfwords and presents one
// aligned (and, with RVC_EN defined, expanded) instruction per handshake.
// Build option: RVC_EN enables compressed detection/expansion and honours
// flush_pc[1]; without it every instruction is treated as 32-bit.
module instr_align
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_instr,
   output logic            in_ready,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            out_compressed,
   output logic            out_illegal
);

   halfword_t        q_q     [QDEPTH];
   halfword_t        q_d     [QDEPTH];
   halfword_t        shifted [QDEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [XLEN-1:0]  head_pc_q, head_pc_d;
   logic             skip_lo_q, skip_lo_d;

   logic             head_c;
   logic [XLEN-1:0]  exp_instr;
   logic             exp_illegal;
   logic             push, pop;
   logic [1:0]       pop_n;
   logic [CNT_W-1:0] base;
   logic [CNT_W-1:0] idx;
   logic             unused_flush_lsb;

   assign unused_flush_lsb = flush_pc[0];

`ifdef RVC_EN
   rvc_expand u_expand (
      .instr_i   (q_q[0]),
      .instr_o   (exp_instr),
      .illegal_o (exp_illegal)
   );
   assign head_c = is_compressed(q_q[0]);
`else
   assign exp_instr   = NOP;
   assign exp_illegal = 1'b0;
   assign head_c      = 1'b0;
`endif

   // Handshakes and the aligned instruction, straight from the queue head.
   always_comb begin
      in_ready       = (count_q <= CNT_W'(2)) & ~flush;
      out_valid      = ~flush & (((count_q >= CNT_W'(1)) & head_c) | (count_q >= CNT_W'(2)));
      out_pc         = head_pc_q;
      out_compressed = head_c;
      out_illegal    = head_c & exp_illegal;
      out_instr      = head_c ? exp_instr : {q_q[1], q_q[0]};
   end

   // Pop from the head, then append the accepted halves behind what remains.
   always_comb begin
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      pop_n     = pop ? (head_c ? 2'd1 : 2'd2) : 2'd0;
      base      = count_q - CNT_W'(pop_n);
      idx       = '0;
      head_pc_d = head_pc_q + (pop ? (head_c ? 32'd2 : 32'd4) : 32'd0);
      skip_lo_d = skip_lo_q;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
         idx        = CNT_W'(i) + CNT_W'(pop_n);
         shifted[i] = (idx < CNT_W'(QDEPTH)) ? q_q[idx[1:0]] : '0;
      end
      q_d     = shifted;
      count_d = base;
      if (push) begin
         if (skip_lo_q) begin
            q_d[base[1:0]] = in_instr[31:16];
            count_d        = base + CNT_W'(1);
            skip_lo_d      = 1'b0;
         end else begin
            q_d[base[1:0]]         = in_instr[15:0];
            q_d[base[1:0] + 2'd1]  = in_instr[31:16];
            count_d                = base + CNT_W'(2);
         end
      end
      if (flush) begin
         q_d       = q_q;
         count_d   = '0;
         head_pc_d = {flush_pc[31:1], 1'b0};
`ifdef RVC_EN
         skip_lo_d = flush_pc[1];
`else
         skip_lo_d = 1'b0;
`endif
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q       <= '{default: '0};
         count_q   <= '0;
         head_pc_q <= RESET_PC;
         skip_lo_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         count_q   <= count_d;
         head_pc_q <= head_pc_d;
         skip_lo_q <= skip_lo_d;
      end
   end

endmodule

// File: tb/tb_instr_align.sv
// Scoreboard bench for instr_align: a halfword-stream model predicts every
// handshake and output; directed cases pin the documented examples.
`timescale 1ns/1ps
module tb_instr_align;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic        out_compressed, out_illegal;
   logic [31:0] in_instr, flush_pc, out_pc, out_instr;

   always #5 clk = ~clk;

   instr_align #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_instr       (in_instr),
      .in_ready       (in_ready),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_compressed (out_compressed),
      .out_illegal    (out_illegal)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        comp;
      logic        ill;
   } obs_t;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] hq[$];     // halfwords accepted but not yet consumed, in PC order
   logic [31:0] hq_pc;     // PC of hq[0]
   bit          m_skip;
   obs_t        obs[$];    // delivered instructions, for the directed examples
   logic [15:0] gen[$];    // stimulus halfword stream waiting to be packed
   int          stall    = 0;
   bit          drain    = 1'b1;
   bit          saw_full = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit is_c(input logic [15:0] h);
      return RVC && (h[1:0] != 2'b11);
   endfunction

   // Only c.li is generated as a legal compressed form; everything else is illegal.
   function automatic logic [32:0] ref_expand(input logic [15:0] h);
      if (h[15:13] == 3'b010 && h[1:0] == 2'b01)
         return {1'b0, {{7{h[12]}}, h[6:2]}, 5'd0, 3'b000, h[11:7], 7'h13};
      return {1'b1, 16'h0000, h};
   endfunction

   function automatic void model_push(input logic [31:0] w);
      if (m_skip) begin
         hq.push_back(w[31:16]);
         m_skip = 1'b0;
      end else begin
         hq.push_back(w[15:0]);
         hq.push_back(w[31:16]);
      end
   endfunction

   // Monitor: compare handshakes every cycle and pop one expected instruction per transfer.
   always @(negedge clk) begin : monitor
      bit          avail;
      logic [15:0] h0;
      logic [32:0] e;
      logic [31:0] exp_instr;
      bit          exp_c, exp_ill;
      int          n;
      if (reset) begin
         hq.delete();
         hq_pc  = RESET_PC;
         m_skip = 1'b0;
      end else begin
         avail = (hq.size() >= 2) || (hq.size() >= 1 && is_c(hq[0]));
         chk("in_ready", 32'(in_ready), 32'((hq.size() <= 2) && !flush));
         chk("out_valid", 32'(out_valid), 32'(avail && !flush));
         if (in_valid && !in_ready && !flush) saw_full = 1'b1;
         if (flush) begin
            hq.delete();
            hq_pc  = {flush_pc[31:1], 1'b0};
            m_skip = RVC && flush_pc[1];
         end else if (out_valid && out_ready && avail) begin
            h0 = hq[0];
            if (is_c(h0)) begin
               e         = ref_expand(h0);
               exp_instr = e[31:0];
               exp_ill   = e[32];
               exp_c     = 1'b1;
               n         = 1;
            end else begin
               exp_instr = {hq[1], h0};
               exp_ill   = 1'b0;
               exp_c     = 1'b0;
               n         = 2;
            end
            chk("out_pc", out_pc, hq_pc);
            chk("out_instr", out_instr, exp_instr);
            chk("out_compressed", 32'(out_compressed), 32'(exp_c));
            chk("out_illegal", 32'(out_illegal), 32'(exp_ill));
            obs.push_back('{out_pc, out_instr, out_compressed, out_illegal});
            hq_pc = hq_pc + 32'(2 * n);
            repeat (n) void'(hq.pop_front());
         end
      end
   end

   // Decode-side backpressure.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stall > 0) begin
            out_ready = 1'b0;
            stall     = stall - 1;
         end else begin
            out_ready = drain || ($urandom_range(3) != 0);
         end
      end
   end

   task automatic send_word(input logic [31:0] w);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_instr = w;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = in_ready;
      end
      #1;
      if (ok) model_push(w);
      else begin
         checks++; failures++;
         $display("FAIL send_timeout actual=in_ready_low required=accept word %h", w);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      @(posedge clk); #1;
      flush    = 1'b0;
      gen.delete();
      if (RVC && pc[1]) gen.push_back(16'h0000);
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk); #2;
         done = (hq.size() == 0) || (hq.size() == 1 && !is_c(hq[0]));
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d halfwords left required=0", hq.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic expect_obs(input string tag, input int k, input logic [31:0] pc,
                             input logic [31:0] instr, input logic comp);
      if (obs.size() > k) begin
         chk({tag, "_pc"}, obs[k].pc, pc);
         chk({tag, "_instr"}, obs[k].instr, instr);
         chk({tag, "_comp"}, 32'(obs[k].comp), 32'(comp));
      end else begin
         checks++; failures++;
         $display("FAIL %s_missing actual=%0d outputs required=more than %0d", tag, obs.size(), k);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] t;
      reset = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; flush_pc = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_pc", out_pc, RESET_PC);
      @(posedge clk); #1;

      // Two plain 32-bit words from the reset PC.
      obs.delete();
      send_word(32'h0000_0013);
      send_word(32'h0010_0093);
      wait_drain();
      expect_obs("ex1_a", 0, 32'h0, 32'h0000_0013, 1'b0);
      expect_obs("ex1_b", 1, 32'h4, 32'h0010_0093, 1'b0);

      // Two compressed instructions packed in one word.
      do_flush(32'h0); obs.delete();
      send_word(32'h4501_4505);
      wait_drain();
`ifdef RVC_EN
      expect_obs("ex2_a", 0, 32'h0, 32'h0010_0513, 1'b1);
      expect_obs("ex2_b", 1, 32'h2, 32'h0000_0513, 1'b1);
`else
      expect_obs("ex2_a", 0, 32'h0, 32'h4501_4505, 1'b0);
`endif

      // 32-bit instruction straddling two fetched words.
      do_flush(32'h0); obs.delete();
      send_word(32'h0093_4505);
      send_word(32'hAAAA_0010);
      wait_drain();
`ifdef RVC_EN
      expect_obs("ex3_a", 0, 32'h0, 32'h0010_0513, 1'b1);
      expect_obs("ex3_b", 1, 32'h2, 32'h0010_0093, 1'b0);
      expect_obs("ex3_c", 2, 32'h6, 32'h0000_AAAA, 1'b1);
`else
      expect_obs("ex3_a", 0, 32'h0, 32'h0093_4505, 1'b0);
      expect_obs("ex3_b", 1, 32'h4, 32'hAAAA_0010, 1'b0);
`endif

      // Redirect into the upper half of a word.
      do_flush(32'h0000_0102); obs.delete();
      send_word(32'h4505_FFFF);
      wait_drain();
`ifdef RVC_EN
      expect_obs("ex4", 0, 32'h102, 32'h0010_0513, 1'b1);
      chk("ex4_single", 32'(obs.size()), 32'd1);
`else
      expect_obs("ex4", 0, 32'h102, 32'h4505_FFFF, 1'b0);
`endif

      // All-zero halfword at the head.
      do_flush(32'h0); obs.delete();
      send_word(32'h4505_0000);
      wait_drain();
`ifdef RVC_EN
      expect_obs("ex6_a", 0, 32'h0, 32'h0000_0000, 1'b1);
      if (obs.size() > 0) chk("ex6_illegal", 32'(obs[0].ill), 32'd1);
      expect_obs("ex6_b", 1, 32'h2, 32'h0010_0513, 1'b1);
`else
      expect_obs("ex6_a", 0, 32'h0, 32'h4505_0000, 1'b0);
`endif

      // Decode stalls while fetch streams 32-bit words: queue fills, nothing lost.
      do_flush(32'h0000_0040); obs.delete();
      saw_full = 1'b0;
      stall    = 4;
      for (int i = 0; i < 5; i++) send_word($urandom() | 32'h3);
      wait_drain();
      chk("stall_saw_full", 32'(saw_full), 32'd1);
      chk("stall_count", 32'(obs.size()), 32'd5);

      // Randomized stream with random backpressure, idles and redirects.
      drain = 1'b0;
      do_flush(32'h0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(31) == 0) begin
            do_flush($urandom());
         end else begin
            if (RVC) begin
               case ($urandom_range(9))
                  0, 1, 2, 3, 4: begin
                     gen.push_back(16'($urandom()) | 16'h3);
                     gen.push_back(16'($urandom()));
                  end
                  5, 6, 7: begin
                     t = {3'b010, 11'($urandom()), 2'b01};
                     gen.push_back(t);
                  end
                  8: gen.push_back(16'h0000);
                  default: begin
                     t = {3'b101, 11'($urandom()), 2'b10};
                     gen.push_back(t);
                  end
               endcase
            end else begin
               gen.push_back(16'($urandom()));
               gen.push_back(16'($urandom()));
            end
            while (gen.size() >= 2) begin
               t = gen.pop_front();
               send_word({gen.pop_front(), t});
            end
            if ($urandom_range(7) == 0) begin
               @(posedge clk); #1;
            end
         end
      end
      drain = 1'b1;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_align.md
INSTR_ALIGN -- requirements
Module: instr_align

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC of first halfword after reset.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  fetched word present.
REQ-005 SHALL have in_instr  input  32  fetched word, little-endian halfwords (low half = lower PC).
REQ-006 SHALL have in_ready  output  1  word accepted this cycle; fetch stall = ~in_ready.
REQ-007 SHALL have flush  input  1  redirect; discard all buffered state.
REQ-008 SHALL have flush_pc  input  32  redirect target; bit 0 ignored.
REQ-009 SHALL have out_valid  output  1  aligned instruction available.
REQ-010 SHALL have out_ready  input  1  decode consumes instruction.
REQ-011 SHALL have out_pc  output  32  PC of out_instr.
REQ-012 SHALL have out_instr  output  32  aligned, expanded 32-bit instruction.
REQ-013 SHALL have out_compressed  output  1  source was a 16-bit instruction.
REQ-014 SHALL have out_illegal  output  1  compressed encoding not expandable.

Function
REQ-015 SHALL hold a halfword queue of capacity 4 with 3-bit count (0..4) and head_pc register.
REQ-016 SHALL drive in_ready = (count <= 2) and ~flush.
REQ-017 SHALL append both halfwords on in_valid & in_ready, low half first; only the high half when skip_lo is set, then clear skip_lo.
REQ-018 SHALL classify head halfword as compressed when bits[1:0] != 2'b11.
REQ-019 SHALL assert out_valid when ~flush and (count >= 1 and head compressed, or count >= 2); otherwise 0.
REQ-020 SHALL present out_* combinationally from queue head; stable while out_valid & ~out_ready.
REQ-021 SHALL on out_valid & out_ready pop 1 halfword and add 2 to head_pc if compressed, else pop 2 and add 4 (32-bit wrap).
REQ-022 SHALL support push and pop in the same cycle; count_next = count + pushed - popped.
REQ-023 SHALL, for a 32-bit instruction, form out_instr = {queue[1], queue[0]} (may straddle fetched words).
REQ-024 SHALL on flush: count <= 0, head_pc <= {flush_pc[31:1],1'b0}, skip_lo <= flush_pc[1]; flush overrides same-cycle push and pop.
REQ-025 SHALL set out_illegal = 1 and out_instr = {16'h0, halfword} for halfword 16'h0000 or any unsupported compressed encoding; out_compressed = 1.
REQ-026 SHALL give zero latency from queue to output; word-in to instruction-out latency is one cycle when queue empty.

Reset
REQ-027 SHALL on reset: count = 0, head_pc = RESET_PC, skip_lo = 0; hence out_valid = 0, in_ready = 1 in the first cycle after reset.
REQ-028 SHALL give reset priority over flush, push and pop.

Configuration
REQ-029 SHALL use macro RVC_EN: defined -> compressed detection, expansion and flush_pc[1] honoured.
REQ-030 SHALL without RVC_EN treat every instruction as 32-bit, tie out_compressed = 0 and out_illegal = 0, and ignore flush_pc[1] (skip_lo never set).

Structure
REQ-031 SHALL place halfword_t, opcode constants and NOP (32'h0000_0013) in shared package rv_pkg.
REQ-032 SHALL implement expansion in combinational sub-module rvc_expand (16-bit in; 32-bit out and illegal flag), instantiated only under RVC_EN.

Verification
REQ-033 Reset, words 32'h0000_0013, 32'h0010_0093 -> out 0x00000013 @pc 0x0, 0x00100093 @pc 0x4, compressed = 0.
REQ-034 Word 32'h4501_4505 -> out 0x00100513 @0x0 then 0x00000513 @0x2, compressed = 1.
REQ-035 Words 32'h0093_4505, 32'hAAAA_0010 -> 0x00100513 @0x0, then 0x00100093 @0x2 (straddle), compressed = 0.
REQ-036 flush, flush_pc = 0x102, word 32'h4505_FFFF -> single out 0x00100513 @0x102; low half discarded.
REQ-037 out_ready = 0 for 4 cycles while streaming 32-bit words -> count saturates at 4, in_ready = 0, no word lost or duplicated after release.
REQ-038 Halfword 16'h0000 at head -> out_illegal = 1, out_instr = 0x00000000, head_pc advances 2.
